// File: rtl/filter_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// filter_buffer_ctrl
//
// Ping-pong filter-tile buffer that answers the PE engine's filter-buffer read
// interface. A loader streams one tile of weights into the free slot while the
// PE reads the other slot with a fixed one-cycle latency. Once the PE side has
// finished an output-channel tile, i_release frees the slot for the loader.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   c_q_channel          tiled input-channel count, sampled on the first
//                        accepted word of each slot (tile length L = q*Tin)
//   i_wr_vld/i_wr_data   loader word stream
//   o_wr_rdy             loader may write
//   i_release            pulse: current read slot is consumed
//   fb_req/fb_addr       PE read request and address
//   o_fb_req_possible    current read slot is full and readable
//   o_fb_data0..3        bank 0..3 read data, valid one cycle after fb_req
//   o_cfg_err            sticky: illegal q_channel on a slot's first word
//   o_rd_err             sticky: read while not possible or address >= L
//
// Handshake: a loader word is transferred on every rising edge where
// i_wr_vld & o_wr_rdy are both high; i_wr_data must be stable while i_wr_vld
// is high, and o_wr_rdy never depends combinationally on i_wr_vld.
// -----------------------------------------------------------------------------
module filter_buffer_ctrl #(
    parameter int FILTER_DW     = 72,
    parameter int Tin           = 4,
    parameter int Tout          = 4,
    parameter int FILTER_BUF_AW = 10,
    parameter int W_SIZE        = 10
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [W_SIZE-1:0]        c_q_channel,
    input  logic                     i_wr_vld,
    input  logic [FILTER_DW-1:0]     i_wr_data,
    output logic                     o_wr_rdy,
    input  logic                     i_release,
    input  logic                     fb_req,
    input  logic [FILTER_BUF_AW-1:0] fb_addr,
    output logic                     o_fb_req_possible,
    output logic [FILTER_DW-1:0]     o_fb_data0,
    output logic [FILTER_DW-1:0]     o_fb_data1,
    output logic [FILTER_DW-1:0]     o_fb_data2,
    output logic [FILTER_DW-1:0]     o_fb_data3,
    output logic                     o_cfg_err,
    output logic                     o_rd_err
);

    localparam int DEPTH = 1 << FILTER_BUF_AW;
    localparam int LW    = FILTER_BUF_AW + 1;   // holds L up to DEPTH inclusive

    typedef enum logic {
        W_IDLE = 1'b0,
        W_FILL = 1'b1
    } wr_state_t;

    wr_state_t                wr_state, wr_state_n;
    logic [1:0]               slot_vld, slot_vld_n;
    logic                     wr_slot, wr_slot_n;
    logic                     rd_slot, rd_slot_n;
    logic [1:0]               wr_bank, wr_bank_n;
    logic [FILTER_BUF_AW-1:0] wr_addr, wr_addr_n;
    logic [LW-1:0]            len_q [2];

    logic                     wr_fire;
    logic                     cfg_ok;
    logic                     last_word;
    logic                     ram_we;
    logic                     rel_ok;
    logic                     rd_ok;
    logic [31:0]              q_len;
    logic [LW-1:0]            fill_len;
    logic [LW-1:0]            rd_len;

    // Slot index is the MSB of the RAM address: {slot, addr}.
    logic [FILTER_DW-1:0]     mem [Tout][2*DEPTH];

    assign wr_fire   = i_wr_vld & o_wr_rdy;
    assign q_len     = 32'(c_q_channel) * 32'(Tin);
    assign cfg_ok    = (c_q_channel != '0) && (q_len <= 32'(DEPTH));
    assign fill_len  = len_q[wr_slot];
    assign last_word = (wr_state == W_FILL) && (wr_bank == 2'(Tout - 1)) &&
                       ({1'b0, wr_addr} == fill_len - LW'(1));
    // In W_IDLE the first word is written only if the configuration is legal.
    assign ram_we    = wr_fire && ((wr_state == W_FILL) || cfg_ok);
    assign rel_ok    = i_release && slot_vld[rd_slot];
    assign rd_len    = len_q[rd_slot];
    assign rd_ok     = fb_req && o_fb_req_possible && ({1'b0, fb_addr} < rd_len);

    // Next-state of the write FSM and the slot bookkeeping. The registered
    // outputs (ready, possible) are derived from these next values so they
    // reflect the slot state right after each edge.
    always_comb begin
        wr_state_n = wr_state;
        slot_vld_n = slot_vld;
        wr_slot_n  = wr_slot;
        rd_slot_n  = rd_slot;
        wr_bank_n  = wr_bank;
        wr_addr_n  = wr_addr;

        if (wr_fire) begin
            case (wr_state)
                W_IDLE: begin
                    if (cfg_ok) begin
                        wr_state_n = W_FILL;
                        wr_bank_n  = 2'd1;
                        wr_addr_n  = '0;
                    end
                end
                W_FILL: begin
                    if (last_word) begin
                        slot_vld_n[wr_slot] = 1'b1;
                        wr_slot_n           = ~wr_slot;
                        wr_bank_n           = '0;
                        wr_addr_n           = '0;
                        wr_state_n          = W_IDLE;
                    end else begin
                        wr_bank_n = wr_bank + 2'd1;
                        if (wr_bank == 2'(Tout - 1)) begin
                            wr_addr_n = wr_addr + 1'b1;
                        end
                    end
                end
                default: wr_state_n = W_IDLE;
            endcase
        end

        // A release always targets the full read slot, while the final write
        // targets the empty write slot, so both may apply on one edge.
        if (rel_ok) begin
            slot_vld_n[rd_slot] = 1'b0;
            rd_slot_n           = ~rd_slot;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_state          <= W_IDLE;
            slot_vld          <= '0;
            wr_slot           <= 1'b0;
            rd_slot           <= 1'b0;
            wr_bank           <= '0;
            wr_addr           <= '0;
            len_q[0]          <= '0;
            len_q[1]          <= '0;
            o_wr_rdy          <= 1'b0;
            o_fb_req_possible <= 1'b0;
            o_fb_data0        <= '0;
            o_fb_data1        <= '0;
            o_fb_data2        <= '0;
            o_fb_data3        <= '0;
            o_cfg_err         <= 1'b0;
            o_rd_err          <= 1'b0;
        end else begin
            wr_state          <= wr_state_n;
            slot_vld          <= slot_vld_n;
            wr_slot           <= wr_slot_n;
            rd_slot           <= rd_slot_n;
            wr_bank           <= wr_bank_n;
            wr_addr           <= wr_addr_n;
            o_wr_rdy          <= (wr_state_n == W_FILL) || !slot_vld_n[wr_slot_n];
            o_fb_req_possible <= slot_vld_n[rd_slot_n];

            // Each slot keeps its own length for read range checks.
            if (wr_fire && (wr_state == W_IDLE) && cfg_ok) begin
                len_q[wr_slot] <= q_len[LW-1:0];
            end
            if (wr_fire && (wr_state == W_IDLE) && !cfg_ok) begin
                o_cfg_err <= 1'b1;
            end

            // Read uses the pre-release slot even when i_release is high.
            if (rd_ok) begin
                o_fb_data0 <= mem[0][{rd_slot, fb_addr}];
                o_fb_data1 <= mem[1][{rd_slot, fb_addr}];
                o_fb_data2 <= mem[2][{rd_slot, fb_addr}];
                o_fb_data3 <= mem[3][{rd_slot, fb_addr}];
            end else if (fb_req) begin
                o_rd_err <= 1'b1;
            end
        end
    end

    // Weight storage is not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[wr_bank][{wr_slot, wr_addr}] <= i_wr_data;
        end
    end

endmodule

// File: tb/tb_filter_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_filter_buffer_ctrl
//
// Directed plus randomized bench for filter_buffer_ctrl. The reference model
// keeps completed tiles as a FIFO of flat word lists (word n of a tile lives in
// bank n%4 at address n/4) and derives every expected output from that FIFO.
// -----------------------------------------------------------------------------
module tb_filter_buffer_ctrl;

    localparam int DW = 72;
    localparam int AW = 10;
    localparam int WS = 10;

    // ---------------------------------------------------------------- clock/reset
    logic          clk = 1'b0;
    logic          rstn;
    logic [WS-1:0] c_q_channel;
    logic          i_wr_vld;
    logic [DW-1:0] i_wr_data;
    logic          o_wr_rdy;
    logic          i_release;
    logic          fb_req;
    logic [AW-1:0] fb_addr;
    logic          o_fb_req_possible;
    logic [DW-1:0] o_fb_data0, o_fb_data1, o_fb_data2, o_fb_data3;
    logic          o_cfg_err;
    logic          o_rd_err;

    always #5 clk = ~clk;

    filter_buffer_ctrl #(
        .FILTER_DW(DW), .Tin(4), .Tout(4), .FILTER_BUF_AW(AW), .W_SIZE(WS)
    ) dut (
        .clk(clk), .rstn(rstn), .c_q_channel(c_q_channel),
        .i_wr_vld(i_wr_vld), .i_wr_data(i_wr_data), .o_wr_rdy(o_wr_rdy),
        .i_release(i_release), .fb_req(fb_req), .fb_addr(fb_addr),
        .o_fb_req_possible(o_fb_req_possible),
        .o_fb_data0(o_fb_data0), .o_fb_data1(o_fb_data1),
        .o_fb_data2(o_fb_data2), .o_fb_data3(o_fb_data3),
        .o_cfg_err(o_cfg_err), .o_rd_err(o_rd_err)
    );

    // ---------------------------------------------------------------- reference model
    logic [DW-1:0] tile_mem [8][4096];
    int            tile_len [8];
    int            tile_q[$];          // completed tiles, oldest first
    int            cur_id;
    int            fill_cnt;
    bit            fill_active;
    bit            exp_rdy;
    bit            exp_cfg_err;
    bit            exp_rd_err;
    logic [DW-1:0] last_data [4];

    int vec_cnt = 0;
    int err_cnt = 0;

    // ---------------------------------------------------------------- scoreboard
    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("wr_rdy",   DW'(o_wr_rdy),          DW'(exp_rdy));
        chk("possible", DW'(o_fb_req_possible), DW'(tile_q.size() > 0));
        chk("data0",    o_fb_data0,             last_data[0]);
        chk("data1",    o_fb_data1,             last_data[1]);
        chk("data2",    o_fb_data2,             last_data[2]);
        chk("data3",    o_fb_data3,             last_data[3]);
        chk("cfg_err",  DW'(o_cfg_err),         DW'(exp_cfg_err));
        chk("rd_err",   DW'(o_rd_err),          DW'(exp_rd_err));
    endtask

    // ---------------------------------------------------------------- driver tasks
    task automatic do_reset();
        i_wr_vld = 1'b0; i_wr_data = '0; i_release = 1'b0; fb_req = 1'b0; fb_addr = '0;
        rstn = 1'b0;
        tile_q.delete();
        fill_active = 1'b0; fill_cnt = 0;
        exp_rdy = 1'b0; exp_cfg_err = 1'b0; exp_rd_err = 1'b0;
        for (int k = 0; k < 4; k++) last_data[k] = '0;
        #2;
        chk_all();
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
    endtask

    // One clock cycle with the given inputs; the model is advanced with the
    // same inputs and all outputs are checked just after the edge.
    task automatic cycle_op(input bit wr, input logic [DW-1:0] wd, input bit rd,
                            input int addr, input bit rel, output bit acc);
        bit done;
        int front;
        i_wr_vld = wr; i_wr_data = wd; fb_req = rd; fb_addr = AW'(addr); i_release = rel;
        acc  = wr && exp_rdy;
        done = 1'b0;
        if (rd) begin
            if (tile_q.size() > 0 && addr < tile_len[tile_q[0]]) begin
                front = tile_q[0];
                for (int k = 0; k < 4; k++) last_data[k] = tile_mem[front][addr*4 + k];
            end else begin
                exp_rd_err = 1'b1;
            end
        end
        if (acc) begin
            if (!fill_active) begin
                if (c_q_channel == 0 || int'(c_q_channel) * 4 > 1024) begin
                    exp_cfg_err = 1'b1;
                end else begin
                    fill_active = 1'b1;
                    fill_cnt = 0;
                    tile_len[cur_id] = int'(c_q_channel) * 4;
                end
            end
            if (fill_active) begin
                tile_mem[cur_id][fill_cnt] = wd;
                fill_cnt++;
                if (fill_cnt == tile_len[cur_id] * 4) done = 1'b1;
            end
        end
        if (rel && tile_q.size() > 0) void'(tile_q.pop_front());
        if (done) begin
            tile_q.push_back(cur_id);
            cur_id = (cur_id + 1) % 8;
            fill_active = 1'b0;
        end
        @(posedge clk);
        #1;
        exp_rdy = fill_active || (tile_q.size() < 2);
        chk_all();
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle_op(1'b0, '0, 1'b0, 0, 1'b0, acc);
    endtask

    task automatic read(input int addr, input bit rel);
        bit acc;
        cycle_op(1'b0, '0, 1'b1, addr, rel, acc);
    endtask

    task automatic release_slot();
        bit acc;
        cycle_op(1'b0, '0, 1'b0, 0, 1'b1, acc);
    endtask

    // Streams one full tile; data is base+n or random. Bounded by a cycle budget.
    task automatic fill(input int q, input bit rnd, input int base, input bit rel_last);
        int n_tot;
        int acc_n;
        int guard;
        bit acc;
        logic [DW-1:0] w;
        c_q_channel = WS'(q);
        n_tot = q * 16;
        acc_n = 0;
        guard = 0;
        while (acc_n < n_tot && guard < n_tot + 20) begin
            w = rnd ? DW'({$urandom(), $urandom(), $urandom()}) : DW'(base + acc_n);
            cycle_op(1'b1, w, 1'b0, 0, rel_last && (acc_n == n_tot - 1), acc);
            if (acc) acc_n++;
            guard++;
        end
        if (acc_n < n_tot) chk("fill_timeout", DW'(acc_n), DW'(n_tot));
        i_wr_vld = 1'b0;
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        bit acc;
        int op;
        int lim;
        rstn = 1'b1; c_q_channel = '0; i_wr_vld = 1'b0; i_wr_data = '0;
        i_release = 1'b0; fb_req = 1'b0; fb_addr = '0;
        cur_id = 0;
        #2;

        // Reset state, then ready rises after the first edge.
        do_reset();
        idle(1);

        // First tile L=8, data n; read address 5 then hold.
        fill(2, 1'b0, 0, 1'b0);
        read(5, 1'b0);
        idle(2);

        // Second slot with data 100+n: loader blocks, release hands over.
        fill(2, 1'b0, 100, 1'b0);
        idle(2);
        release_slot();
        read(0, 1'b0);
        release_slot();
        read(3, 1'b0);               // no valid slot
        idle(1);

        // Address at the tile length.
        do_reset();
        fill(2, 1'b1, 0, 1'b0);
        read(7, 1'b0);
        read(8, 1'b0);
        read(2, 1'b0);

        // Illegal configurations, then the largest legal tile.
        do_reset();
        idle(1);
        c_q_channel = WS'(0);
        cycle_op(1'b1, DW'(55), 1'b0, 0, 1'b0, acc);
        c_q_channel = WS'(300);
        cycle_op(1'b1, DW'(66), 1'b0, 0, 1'b0, acc);
        idle(1);
        fill(256, 1'b1, 0, 1'b0);
        read(1023, 1'b0);
        read(0, 1'b0);

        // Reset in the middle of a fill.
        do_reset();
        idle(1);
        c_q_channel = WS'(2);
        for (int i = 0; i < 10; i++) cycle_op(1'b1, DW'(900 + i), 1'b0, 0, 1'b0, acc);
        do_reset();
        idle(1);
        fill(2, 1'b0, 0, 1'b0);
        read(0, 1'b0);

        // Randomized traffic including same-edge release with read or final write.
        do_reset();
        idle(1);
        for (int r = 0; r < 80; r++) begin
            op = $urandom_range(0, 5);
            case (op)
                0, 1: begin
                    if (tile_q.size() < 2)
                        fill($urandom_range(1, 4), 1'b1, 0, 1'($urandom_range(0, 1)));
                    else
                        idle(1);
                end
                2, 3: begin
                    lim = (tile_q.size() > 0) ? tile_len[tile_q[0]] + 2 : 15;
                    read($urandom_range(0, lim), 1'($urandom_range(0, 3) == 0));
                end
                4: release_slot();
                default: idle(1);
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
